// File: rtl/io_pkg.sv
// Shared constants for the packed IO status word, common to io_input_cond and
// datamem's IO window decoder.
package io_pkg;

  localparam int IOIN_STICKY_LSB = 16;
  localparam int IO_MAX_WIDTH    = 16;

endpackage

// File: rtl/io_input_cond_debounce_bit.sv
// One conditioned input bit: synchroniser chain, debounce counter, stable level,
// registered rising-edge pulse and sticky press flag.
module debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pinIn,
  input  logic clrSticky,
  output logic stable,
  output logic edgePulse,
  output logic sticky
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] syncChain_p0;
  logic                   sync_p1;
  logic [CNT_W-1:0]       cnt;
  logic                   flip;
  logic                   rise;

  assign sync_p1 = syncChain_p0[SYNC_STAGES-1];
  // A flip is accepted only on the last of DEBOUNCE_CYCLES consecutive mismatches.
  assign flip    = (sync_p1 != stable) && (cnt == CNT_LAST);
  assign rise    = flip && sync_p1;

  // Synchroniser stage
  always_ff @(posedge clk) begin
    if (!rst) syncChain_p0 <= '0;
    else      syncChain_p0 <= {syncChain_p0[SYNC_STAGES-2:0], pinIn};
  end

  // Debounce / edge / sticky stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      stable    <= 1'b0;
      edgePulse <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      edgePulse <= rise;
      // A new press outranks a simultaneous clear so it is never lost.
      if (rise)           sticky <= 1'b1;
      else if (clrSticky) sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/io_input_cond.sv
// Conditions raw board inputs into debounced levels and sticky press flags,
// packed into the cpu's 32-bit ioin word.
module io_input_cond
  import io_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [WIDTH-1:0] clr_sticky,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [31:0]      ioin
);

  if (WIDTH < 1 || WIDTH > IO_MAX_WIDTH) begin : gWidthCheck
    $error("io_input_cond: WIDTH must be 1..%0d", IO_MAX_WIDTH);
  end
  if (SYNC_STAGES < 2) begin : gSyncCheck
    $error("io_input_cond: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : gDebCheck
    $error("io_input_cond: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] sticky;

  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uBit (
      .clk      (clk),
      .rst      (rst),
      .pinIn    (pins_in[i]),
      .clrSticky(clr_sticky[i]),
      .stable   (stable[i]),
      .edgePulse(edge_pulse[i]),
      .sticky   (sticky[i])
    );
  end

  always_comb begin
    ioin = '0;
    ioin[WIDTH-1:0]                 = stable;
    ioin[IOIN_STICKY_LSB +: WIDTH]  = sticky;
  end

endmodule

// File: tb/tb_io_input_cond.sv
// Directed bench for io_input_cond with WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_io_input_cond;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pins_in = '0;
  logic [7:0]  clr_sticky = '0;
  logic [7:0]  edge_pulse;
  logic [31:0] ioin;

  int checks = 0;
  int errors = 0;

  io_input_cond #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pins_in   (pins_in),
    .clr_sticky(clr_sticky),
    .edge_pulse(edge_pulse),
    .ioin      (ioin)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [7:0] pins);
    pins_in    = pins;
    clr_sticky = '0;
    rst        = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    pins_in = 8'hFF;
    rst     = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (ioin !== 32'h0 || edge_pulse !== 8'h0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d ioin=%h edge=%h want 0/0", n, ioin, edge_pulse);
      end
    end
    rst = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      checks++;
      if (n < 6) begin
        if (ioin !== 32'h0 || edge_pulse !== 8'h0) begin
          errors++;
          $display("FAIL reset_release edge%0d ioin=%h edge=%h want 0/0", n, ioin, edge_pulse);
        end
      end else if (n == 6) begin
        if (ioin !== 32'h00FF_00FF || edge_pulse !== 8'hFF) begin
          errors++;
          $display("FAIL reset_release edge6 ioin=%h edge=%h want 00ff00ff/ff", ioin, edge_pulse);
        end
      end else begin
        if (ioin !== 32'h00FF_00FF || edge_pulse !== 8'h00) begin
          errors++;
          $display("FAIL reset_release edge7 ioin=%h edge=%h want 00ff00ff/00", ioin, edge_pulse);
        end
      end
    end
  endtask

  task automatic test_glitch();
    doReset(8'h00);
    pins_in = 8'h01;
    for (int n = 0; n < 12; n++) begin
      if (n == 3) pins_in = 8'h00;
      tick();
      checks++;
      if (ioin !== 32'h0 || edge_pulse !== 8'h0) begin
        errors++;
        $display("FAIL glitch cyc%0d ioin=%h edge=%h want 0/0", n, ioin, edge_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    int pulses;
    pat = 7'b1111011;
    doReset(8'h00);
    for (int n = 0; n < 4; n++) begin
      pins_in[1] = pat[n];
      tick();
      checks++;
      if (ioin !== 32'h0) begin
        errors++;
        $display("FAIL bounce_pre cyc%0d ioin=%h want 0", n, ioin);
      end
    end
    pulses = 1;
    for (int n = 2; n <= 10; n++) begin
      pins_in[1] = 1'b1;
      tick();
      if (edge_pulse[1]) pulses++;
      if (n == 5) begin
        checks++;
        if (ioin[1] !== 1'b0) begin
          errors++;
          $display("FAIL bounce_early edge5 ioin[1]=%b want 0", ioin[1]);
        end
      end
      if (n == 6) begin
        checks++;
        if (ioin !== 32'h0002_0002 || edge_pulse !== 8'h02) begin
          errors++;
          $display("FAIL bounce_rise edge6 ioin=%h edge=%h want 00020002/02", ioin, edge_pulse);
        end
      end
    end
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL bounce_pulse_count got=%0d want 2 (incl. start offset 1)", pulses);
    end
  endtask

  task automatic test_sticky_clear();
    doReset(8'h00);
    pins_in = 8'h01;
    repeat (6) tick();
    checks++;
    if (ioin !== 32'h0001_0001) begin
      errors++;
      $display("FAIL sticky_setup ioin=%h want 00010001", ioin);
    end
    clr_sticky = 8'h01;
    tick();
    clr_sticky = 8'h00;
    checks++;
    if (ioin !== 32'h0000_0001) begin
      errors++;
      $display("FAIL sticky_clear ioin=%h want 00000001", ioin);
    end
    clr_sticky = 8'h02;
    tick();
    clr_sticky = 8'h00;
    checks++;
    if (ioin !== 32'h0000_0001) begin
      errors++;
      $display("FAIL sticky_clear_idle ioin=%h want 00000001", ioin);
    end
    pins_in = 8'h00;
    repeat (6) tick();
    checks++;
    if (ioin !== 32'h0) begin
      errors++;
      $display("FAIL sticky_fall ioin=%h want 0", ioin);
    end
    pins_in = 8'h01;
    repeat (5) tick();
    clr_sticky = 8'h01;
    tick();
    clr_sticky = 8'h00;
    checks++;
    if (ioin !== 32'h0001_0001 || edge_pulse !== 8'h01) begin
      errors++;
      $display("FAIL sticky_set_wins ioin=%h edge=%h want 00010001/01", ioin, edge_pulse);
    end
  endtask

  task automatic test_reset_midcount();
    doReset(8'h00);
    pins_in = 8'h04;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (ioin !== 32'h0) begin
      errors++;
      $display("FAIL midreset_hold ioin=%h want 0", ioin);
    end
    rst = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n == 5) begin
        checks++;
        if (ioin[2] !== 1'b0) begin
          errors++;
          $display("FAIL midreset_early edge5 ioin[2]=%b want 0", ioin[2]);
        end
      end
      if (n == 6) begin
        checks++;
        if (ioin !== 32'h0004_0004) begin
          errors++;
          $display("FAIL midreset_rise edge6 ioin=%h want 00040004", ioin);
        end
      end
    end
  endtask

  task automatic test_fall();
    pins_in = 8'h0C;
    repeat (6) tick();
    checks++;
    if (ioin !== 32'h000C_000C) begin
      errors++;
      $display("FAIL fall_setup ioin=%h want 000c000c", ioin);
    end
    pins_in = 8'h04;
    for (int n = 1; n <= 6; n++) begin
      tick();
      checks++;
      if (edge_pulse !== 8'h00) begin
        errors++;
        $display("FAIL fall_pulse edge%0d edge=%h want 00", n, edge_pulse);
      end
      if (n == 5) begin
        checks++;
        if (ioin !== 32'h000C_000C) begin
          errors++;
          $display("FAIL fall_early edge5 ioin=%h want 000c000c", ioin);
        end
      end
      if (n == 6) begin
        checks++;
        if (ioin !== 32'h000C_0004) begin
          errors++;
          $display("FAIL fall_level edge6 ioin=%h want 000c0004", ioin);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_sticky_clear();
    test_reset_midcount();
    test_fall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
